// File: rtl/d_bridge_pkg.sv
// Shared types for the sram-like to AXI bridges: FSM state encoding and
// the sram-like transfer size codes.
package d_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generator: maps sram-like size and low address bits to
// AXI wstrb. Size code 3 is treated as a full word.
module axi_wstrb_gen
  import d_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    // NOTE: default assigned before the case so every path drives wstrb and no latch is inferred.
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/d_sram_axi_bridge.sv
// Data-side bridge: turns one sram-like request at a time into a single-beat
// AXI read (AR/R) or write (AW+W/B) and returns a one-cycle data_ok.
module d_sram_axi_bridge
  import d_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [31:0]           rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  state_e                state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           wdata_q, wdata_d;

  axi_wstrb_gen u_wstrb_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign arsize     = {1'b0, size_q};
  assign awsize     = {1'b0, size_q};
  assign wdata      = wdata_q;
  assign data_rdata = rdata;

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_req && !rst) begin
          data_addr_ok = 1'b1;
          addr_d       = data_addr;
          size_d       = data_size;
          wdata_d      = data_wdata;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          state_d      = data_wr ? ST_WR : ST_AR;
        end
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        // Readies and data_ok are held off during reset so an abandoned
        // transaction neither consumes a beat nor completes to the cache.
        rready = !rst;
        if (rvalid && !rst) begin
          data_data_ok = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WR: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = ST_B;
      end
      ST_B: begin
        bready = !rst;
        if (bvalid && !rst) begin
          data_data_ok = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while a valid is asserted.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Self-checking bench for d_sram_axi_bridge: directed scenarios plus a
// randomized transaction loop checked against a byte-lane reference model.
module tb_d_sram_axi_bridge;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata, data_rdata;
  logic          data_addr_ok, data_data_ok;
  logic [AW-1:0] araddr, awaddr;
  logic [2:0]    arsize, awsize;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   rdata, wdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  d_sram_axi_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference strobe: an access of 2^size bytes (size 3 = 4 bytes), lanes
  // start at the address rounded down to the access width.
  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [AW-1:0] addr);
    int nbytes, lo, base, mask;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lo     = int'(addr[1:0]);
    base   = lo - (lo % nbytes);
    mask   = (1 << nbytes) - 1;
    return 4'(mask << base);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read: accept, AR stalled ar_d cycles, R delayed r_d cycles. With intrude
  // set, a competing request and a premature rvalid are driven during AR.
  task automatic do_read(input logic [AW-1:0] addr, input logic [1:0] size,
                         input logic [31:0] rd_val, input int ar_d, input int r_d,
                         input bit intrude);
    data_req = 1'b1; data_wr = 1'b0; data_size = size; data_addr = addr;
    data_wdata = $urandom;
    @(negedge clk);
    check("rd_accept_addr_ok", 32'(data_addr_ok), 32'd1);
    check("rd_accept_no_data_ok", 32'(data_data_ok), 32'd0);
    next_cycle();
    data_req = intrude; data_addr = ~addr; data_size = 2'(~size);
    for (int c = 0; c <= ar_d; c++) begin
      arready = (c == ar_d);
      rvalid  = intrude;
      @(negedge clk);
      check("ar_arvalid", 32'(arvalid), 32'd1);
      check("ar_araddr", araddr, addr);
      check("ar_arsize", 32'(arsize), 32'({1'b0, size}));
      check("ar_no_addr_ok", 32'(data_addr_ok), 32'd0);
      check("ar_rready_low", 32'(rready), 32'd0);
      check("ar_no_data_ok", 32'(data_data_ok), 32'd0);
      next_cycle();
    end
    arready = 1'b0; data_req = 1'b0;
    for (int c = 0; c <= r_d; c++) begin
      rvalid = (c == r_d);
      rdata  = (c == r_d) ? rd_val : $urandom;
      @(negedge clk);
      check("r_rready", 32'(rready), 32'd1);
      check("r_arvalid_low", 32'(arvalid), 32'd0);
      check("r_data_ok", 32'(data_data_ok), 32'(c == r_d));
      if (c == r_d) check("r_rdata", data_rdata, rd_val);
      next_cycle();
    end
    rvalid = 1'b0;
  endtask

  // Write: AW ready after aw_d cycles, W after w_d, B after b_d. With
  // next_rd set, a read request is held pending while B is outstanding.
  task automatic do_write(input logic [AW-1:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input int aw_d, input int w_d,
                          input int b_d, input bit next_rd);
    int last;
    logic [3:0] strb;
    strb = model_strb(size, addr);
    last = (aw_d > w_d) ? aw_d : w_d;
    data_req = 1'b1; data_wr = 1'b1; data_size = size; data_addr = addr; data_wdata = wd;
    @(negedge clk);
    check("wr_accept_addr_ok", 32'(data_addr_ok), 32'd1);
    next_cycle();
    data_req = 1'b0; data_wdata = ~wd; data_addr = ~addr;
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_d);
      wready  = (c == w_d);
      @(negedge clk);
      check("wr_awvalid", 32'(awvalid), 32'(c <= aw_d));
      check("wr_wvalid", 32'(wvalid), 32'(c <= w_d));
      check("wr_awaddr", awaddr, addr);
      check("wr_awsize", 32'(awsize), 32'({1'b0, size}));
      check("wr_wdata", wdata, wd);
      check("wr_wstrb", 32'(wstrb), 32'(strb));
      check("wr_bready_low", 32'(bready), 32'd0);
      check("wr_no_data_ok", 32'(data_data_ok), 32'd0);
      next_cycle();
    end
    awready = 1'b0; wready = 1'b0;
    for (int c = 0; c <= b_d; c++) begin
      bvalid = (c == b_d);
      if (next_rd) begin
        data_req = 1'b1; data_wr = 1'b0;
      end
      @(negedge clk);
      check("b_bready", 32'(bready), 32'd1);
      check("b_awvalid_low", 32'(awvalid), 32'd0);
      check("b_wvalid_low", 32'(wvalid), 32'd0);
      check("b_data_ok", 32'(data_data_ok), 32'(c == b_d));
      check("b_no_addr_ok", 32'(data_addr_ok), 32'd0);
      next_cycle();
    end
    bvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // Reset: nothing accepted, all handshake outputs low.
    next_cycle();
    @(negedge clk);
    check("rst_addr_ok", 32'(data_addr_ok), 32'd0);
    check("rst_valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
    check("rst_readies", 32'({rready, bready, data_data_ok}), 32'd0);
    next_cycle();
    rst = 1'b0; data_req = 1'b0;
    next_cycle();

    // Word read, zero-wait slave.
    do_read(32'h0000_1004, 2'd2, 32'hDEAD_BEEF, 0, 0, 1'b0);

    // Byte write to the top lane, B delayed.
    do_write(32'h0000_2003, 2'd0, 32'hAB00_0000, 0, 0, 2, 1'b0);

    // W handshake three cycles ahead of AW.
    do_write(32'h0000_3002, 2'd1, 32'h1234_5678, 3, 0, 0, 1'b0);

    // Dirty-miss pattern: write with a read held pending, then the read.
    do_write(32'h0000_4000, 2'd2, 32'hCAFE_F00D, 1, 1, 1, 1'b1);
    do_read(32'h0000_5008, 2'd2, 32'h0BAD_C0DE, 0, 0, 1'b0);

    // arready low for five cycles with a competing request and early rvalid.
    do_read(32'h0000_6001, 2'd0, 32'h5555_AAAA, 5, 1, 1'b1);

    // Reset while in R with rvalid asserted.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_7000;
    @(negedge clk);
    check("rstR_accept", 32'(data_addr_ok), 32'd1);
    next_cycle();
    data_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    check("rstR_arvalid", 32'(arvalid), 32'd1);
    next_cycle();
    arready = 1'b0; rst = 1'b1; rvalid = 1'b1; rdata = 32'h7777_7777; data_req = 1'b1;
    @(negedge clk);
    check("rstR_no_data_ok", 32'(data_data_ok), 32'd0);
    check("rstR_no_addr_ok", 32'(data_addr_ok), 32'd0);
    check("rstR_rready_low", 32'(rready), 32'd0);
    next_cycle();
    rst = 1'b0; rvalid = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("post_rst_outputs",
          32'({arvalid, awvalid, wvalid, rready, bready, data_data_ok, data_addr_ok}), 32'd0);
    next_cycle();
    do_read(32'h0000_7004, 2'd1, 32'h8888_9999, 0, 0, 1'b0);

    // Randomized mix of reads and writes, all sizes including code 3.
    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      logic [1:0]    s;
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, s, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else
        do_read(a, s, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
